// File: rtl/noc_pkt_pkg.sv
// noc_pkt_pkg: shared NoC flit layout (dest X/Y, packet number, payload bytes)
package noc_pkt_pkg;
  localparam int X_SIZE = 2;
  localparam int Y_SIZE = 2;
  localparam int PCK_NUM = 3;
  localparam int ITER = 4;
  function automatic int addr_lsb();
    return 0;
  endfunction
  function automatic int pck_lsb(int x, int y);
    return x + y;
  endfunction
  function automatic int payload_lsb(int x, int y, int p);
    return x + y + p;
  endfunction
  function automatic int payload_width(int it);
    return 8 * it;
  endfunction
  typedef struct packed {
    logic [8*ITER-1:0] payload;
    logic [PCK_NUM-1:0] pck;
    logic [Y_SIZE-1:0] y;
    logic [X_SIZE-1:0] x;
  } noc_pkt_t;
endpackage

// File: rtl/collector_slot_ram.sv
// collector_slot_ram: per-packet-number payload slots with valid bits, async read at exp
module collector_slot_ram #(
  parameter int depth_bits = 3,
  parameter int width = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [depth_bits-1:0] waddr,
  input  logic [width-1:0] wdata,
  input  logic clr,
  input  logic [depth_bits-1:0] raddr,
  output logic [width-1:0] rdata,
  output logic [2**depth_bits-1:0] vld
);
  logic [width-1:0] mem [2**depth_bits];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (!rst) vld <= '0;
    else begin
      if (clr) vld[raddr] <= 1'b0;
      if (we) vld[waddr] <= 1'b1;
    end
  assign rdata = mem[raddr];
endmodule

// File: rtl/reorder_collector.sv
// reorder_collector: restores packet-number order of NoC packets; stats ports under REORDER_STATS_EN
module reorder_collector
  import noc_pkt_pkg::*;
#(
  parameter int x_size = 2,
  parameter int y_size = 2,
  parameter int pck_num = 3,
  parameter int iter = 4,
  parameter int total_width = x_size + y_size + pck_num + 8*iter
) (
  input  logic clk,
  input  logic rst,
  input  logic [total_width-1:0] i_data,
  input  logic i_valid,
  output logic o_ready,
  output logic [8*iter-1:0] o_data,
  output logic [pck_num-1:0] o_pck,
  output logic o_last,
  output logic o_valid,
  input  logic i_ready
`ifdef REORDER_STATS_EN
  ,
  output logic [31:0] o_ooo_cnt,
  output logic [31:0] o_stall_cnt
`endif
);
  localparam int pl = pck_lsb(x_size, y_size);
  localparam int dl = payload_lsb(x_size, y_size, pck_num);
  localparam int w = payload_width(iter);
  logic [pck_num-1:0] pck_in, exp;
  logic [w-1:0] pay_in, rdata;
  logic [2**pck_num-1:0] vld;
  logic acc, free, bypass, drain, we, unused_bits;
  assign pck_in = i_data[pl +: pck_num];
  assign pay_in = i_data[dl +: w];
  assign unused_bits = ^i_data;
  assign o_ready = rst & ~vld[pck_in];
  assign acc = i_valid & o_ready;
  assign free = ~o_valid | i_ready;
  assign bypass = acc & (pck_in == exp) & free;
  // an accept never targets slot exp while it is valid, so drain and write never collide
  assign drain = ~bypass & vld[exp] & free;
  assign we = acc & ~bypass;
  collector_slot_ram #(.depth_bits(pck_num), .width(w)) u_ram (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(pck_in),
    .wdata(pay_in),
    .clr(drain),
    .raddr(exp),
    .rdata(rdata),
    .vld(vld)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      exp <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_pck <= '0;
      o_last <= 1'b0;
    end else if (bypass | drain) begin
      exp <= exp + 1'b1;
      o_valid <= 1'b1;
      o_data <= bypass ? pay_in : rdata;
      o_pck <= exp;
      o_last <= &exp;
    end else if (i_ready) o_valid <= 1'b0;
`ifdef REORDER_STATS_EN
  always_ff @(posedge clk)
    if (!rst) begin
      o_ooo_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (acc && pck_in != exp && !(&o_ooo_cnt)) o_ooo_cnt <= o_ooo_cnt + 32'd1;
      if (i_valid && !o_ready && !(&o_stall_cnt)) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_reorder_collector.sv
// tb_reorder_collector: directed self-checking bench for reorder_collector
module tb_reorder_collector;
  import noc_pkt_pkg::*;
  localparam int tw = X_SIZE + Y_SIZE + PCK_NUM + 8*ITER;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [tw-1:0] i_data = '0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b1;
  logic o_ready, o_last, o_valid;
  logic [8*ITER-1:0] o_data;
  logic [PCK_NUM-1:0] o_pck;
`ifdef REORDER_STATS_EN
  logic [31:0] o_ooo_cnt, o_stall_cnt;
`endif
  int tests = 0;
  int fails = 0;
  int lasts = 0;
  logic rw_hit = 1'b0;
  always #5 clk = ~clk;
  reorder_collector #(.x_size(X_SIZE), .y_size(Y_SIZE), .pck_num(PCK_NUM), .iter(ITER), .total_width(tw)) dut (
    .clk(clk),
    .rst(rst),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data(o_data),
    .o_pck(o_pck),
    .o_last(o_last),
    .o_valid(o_valid),
    .i_ready(i_ready)
`ifdef REORDER_STATS_EN
    ,
    .o_ooo_cnt(o_ooo_cnt),
    .o_stall_cnt(o_stall_cnt)
`endif
  );
  // a slot must never be written and drained in the same cycle
  always @(negedge clk)
    if (rst) begin
      assert (!(dut.we && dut.drain && dut.pck_in == dut.exp))
      else begin
        rw_hit = 1'b1;
        $error("FAIL same_slot_rw: slot %0d written and drained together", dut.exp);
      end
    end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int p, input logic [31:0] pay);
    noc_pkt_t pk;
    pk = '{payload: pay, pck: PCK_NUM'(p), y: '0, x: '0};
    i_data = pk;
    i_valid = 1'b1;
    #1;
  endtask
  task automatic idle();
    i_valid = 1'b0;
    #1;
  endtask
  task automatic out(input string tag, input int p, input logic [31:0] pay);
    chk({tag, "_valid"}, 64'(o_valid), 64'd1);
    chk({tag, "_pck"}, 64'(o_pck), 64'(p));
    chk({tag, "_data"}, 64'(o_data), 64'(pay));
    chk({tag, "_last"}, 64'(o_last), 64'(p == 7));
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_pck", 64'(o_pck), 64'd0);
    chk("rst_last", 64'(o_last), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 64'(o_ready), 64'd1);
    for (int p = 0; p < 8; p++) begin
      send(p, 32'(p << 4));
      chk("inorder_ready", 64'(o_ready), 64'd1);
      tick();
      out("inorder", p, 32'(p << 4));
    end
    idle();
    tick();
    chk("inorder_drain", 64'(o_valid), 64'd0);
    send(2, 32'hA2);
    tick();
    chk("reord_wait2", 64'(o_valid), 64'd0);
    send(1, 32'hA1);
    tick();
    chk("reord_wait1", 64'(o_valid), 64'd0);
    send(3, 32'hA3);
    tick();
    chk("reord_wait3", 64'(o_valid), 64'd0);
    send(0, 32'hA0);
    tick();
    out("reord0", 0, 32'hA0);
    idle();
    tick();
    out("reord1", 1, 32'hA1);
    tick();
    out("reord2", 2, 32'hA2);
    tick();
    out("reord3", 3, 32'hA3);
    tick();
    chk("reord_end", 64'(o_valid), 64'd0);
    i_ready = 1'b0;
    send(4, 32'hB4);
    tick();
    out("bp_first", 4, 32'hB4);
    send(5, 32'hB5);
    tick();
    out("bp_hold1", 4, 32'hB4);
    send(6, 32'hB6);
    tick();
    out("bp_hold2", 4, 32'hB4);
    idle();
    tick();
    out("bp_hold3", 4, 32'hB4);
    i_ready = 1'b1;
    tick();
    out("bp_rel5", 5, 32'hB5);
    tick();
    out("bp_rel6", 6, 32'hB6);
    tick();
    chk("bp_end", 64'(o_valid), 64'd0);
    send(7, 32'h70);
    tick();
    out("occ_pre7", 7, 32'h70);
    idle();
    tick();
    chk("occ_idle", 64'(o_valid), 64'd0);
    send(5, 32'h51);
    tick();
    chk("occ_store", 64'(o_valid), 64'd0);
    send(5, 32'h52);
    chk("occ_stall_a", 64'(o_ready), 64'd0);
    tick();
    chk("occ_stall_b", 64'(o_ready), 64'd0);
    chk("occ_stall_v", 64'(o_valid), 64'd0);
    for (int p = 0; p < 5; p++) begin
      send(p, 32'(32'h60 + p));
      tick();
      out("occ_fill", p, 32'(32'h60 + p));
    end
    send(5, 32'h52);
    chk("occ_stall_c", 64'(o_ready), 64'd0);
    tick();
    out("occ_first5", 5, 32'h51);
    chk("occ_free", 64'(o_ready), 64'd1);
    tick();
    chk("occ_second_store", 64'(o_valid), 64'd0);
    for (int k = 0; k < 7; k++) begin
      send((6 + k) % 8, 32'(32'h70 + k));
      tick();
      out("occ_window", (6 + k) % 8, 32'(32'h70 + k));
    end
    idle();
    tick();
    out("occ_second5", 5, 32'h52);
    tick();
    chk("occ_end", 64'(o_valid), 64'd0);
    send(6, 32'h86);
    tick();
    send(7, 32'h87);
    tick();
    out("wrap_pre7", 7, 32'h87);
    for (int i = 0; i < 20; i++) begin
      send(i % 8, 32'(32'h1000 + i));
      tick();
      out("wrap", i % 8, 32'(32'h1000 + i));
      if (o_last) lasts++;
    end
    idle();
    tick();
    chk("wrap_last_count", 64'(lasts), 64'd2);
    chk("wrap_end", 64'(o_valid), 64'd0);
    i_ready = 1'b0;
    send(5, 32'h55);
    tick();
    send(7, 32'h57);
    tick();
    chk("mrst_buffered", 64'(o_valid), 64'd0);
    send(4, 32'h54);
    tick();
    out("mrst_held", 4, 32'h54);
    idle();
    rst = 1'b0;
    tick();
    chk("mrst_valid", 64'(o_valid), 64'd0);
    chk("mrst_data", 64'(o_data), 64'd0);
    chk("mrst_pck", 64'(o_pck), 64'd0);
    rst = 1'b1;
    i_ready = 1'b1;
    send(0, 32'hC0);
    tick();
    out("mrst_first", 0, 32'hC0);
    for (int p = 1; p < 5; p++) begin
      send(p, 32'(32'hC0 + p));
      tick();
      out("mrst_seq", p, 32'(32'hC0 + p));
    end
    idle();
    tick();
    chk("mrst_no_stale_a", 64'(o_valid), 64'd0);
    tick();
    chk("mrst_no_stale_b", 64'(o_valid), 64'd0);
    send(7, 32'hD7);
    i_valid = 1'b0;
    #1;
    chk("mrst_slot7_free", 64'(o_ready), 64'd1);
    chk("no_same_slot_rw", 64'(rw_hit), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reorder_collector.md
Name: reorder_collector

Overview:
- Sink-side stage at NoC node (0,0), directly downstream of the inverter PE.
- Accepts inverted-data packets, which may arrive out of order because the mesh routes them independently.
- Buffers each packet in a slot indexed by its packet-number field.
- Streams payloads out strictly in ascending packet-number order, wrapping modulo 2**pck_num, to the host/DMA side.

Parameters:
- total_width, 0: NoC flit width. Must be >= x_size+y_size+pck_num+8*iter.
- x_size, 0: width of the X destination field, located at bit 0.
- y_size, 0: width of the Y destination field, located above X.
- pck_num, 0: width of the packet-number field, located at [x_size+y_size +: pck_num]. Buffer depth is 2**pck_num.
- iter, 0: payload bytes per packet. Byte k is at [x_size+y_size+pck_num+8*k +: 8].

Ports:
- clk  in  1: single clock.
- rst  in  1: reset, synchronous, active-low.
- i_data  in  total_width: flit from the NoC.
- i_valid  in  1: i_data valid.
- o_ready  out  1: collector can accept i_data.
- o_data  out  8*iter: in-order payload.
- o_pck  out  pck_num: packet number of o_data.
- o_last  out  1: o_pck == 2**pck_num-1.
- o_valid  out  1: o_data/o_pck/o_last valid.
- i_ready  in  1: downstream accepts the output.

Behaviour:
- Reset (rst==0 at posedge):
  - all slot-valid bits cleared; exp (expected packet number) = 0.
  - o_valid=0, o_data=0, o_pck=0, o_last=0.
  - Slot payload contents are don't-care.
  - Reset mid-operation discards all buffered and in-flight packets. The first accepted packet after reset is treated against exp=0.
- Input handshake:
  - o_ready = rst & ~slot_valid[i_data.pck], combinational.
  - Accept when i_valid & o_ready. Destination bits are ignored.
  - A packet whose slot is already occupied (duplicate, or more than a window ahead) is stalled, never overwritten or dropped.
- Output register: single entry. "Free" means ~o_valid | i_ready.
- Per-cycle priority, evaluated at each posedge:
  1. Bypass: accept with pck==exp and output register free.
     - Load the payload directly into the output register; slot is not written.
     - exp <= exp+1; o_valid <= 1.
     - Latency accept -> o_valid = 1 cycle.
  2. Otherwise, slot_valid[exp] set and output register free.
     - Load the slot into the output register; clear slot_valid[exp]; exp <= exp+1.
     - A simultaneous accept for a different slot writes that slot in the same cycle.
  3. Otherwise, an accept writes its slot and sets its valid bit.
     - A packet for exp arriving while the output register is held becomes visible 1 cycle after the output register frees.
- Output side:
  - When o_valid & i_ready and nothing is loaded, o_valid <= 0.
  - o_data, o_pck and o_last hold stable while o_valid & ~i_ready.
- Arithmetic:
  - exp is pck_num bits and wraps 2**pck_num-1 -> 0.
  - Window full (all slots valid except exp): o_ready stays high only for pck==exp.
- Throughput: one packet per cycle in and out when in order and i_ready=1.
- A write and a read of the same slot in one cycle is impossible by construction. The bench must assert this never occurs.

Optional Feature:
- REORDER_STATS_EN defined:
  - Adds output o_ooo_cnt [31:0]: packets accepted with pck != exp.
  - Adds output o_stall_cnt [31:0]: cycles with i_valid & ~o_ready.
  - Both counters reset to 0 and saturate at all-ones.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package noc_pkt_pkg:
  - field-offset localparams/functions: addr_lsb, pck_lsb, payload_lsb, payload_width(iter).
  - the packet struct typedef, so the inverter, collector and generator agree on the layout.
- One natural sub-module, collector_slot_ram:
  - 2**pck_num x 8*iter storage plus valid vector.
  - 1 write port, 1 asynchronous read port at exp, set/clear of valid bits.
- Top level holds exp, the bypass mux and the output register.

Test Plan (x_size=2, y_size=2, pck_num=3, iter=4):
- In-order: pck 0..7 back-to-back with payload 0x000000P0 each, i_ready=1 -> o_valid from the cycle after the first accept; o_pck 0..7 consecutive; o_last only on 7; o_ready constant 1.
- Reorder: send pck 2,1,3,0 -> no o_valid until pck 0 is accepted, then o_pck 0,1,2,3 on 4 consecutive cycles with the matching payloads.
- Backpressure: i_ready=0 while sending 0,1,2 -> o_pck=0 held stable. Release i_ready -> 0,1,2 delivered in order, none lost.
- Occupied slot: with exp=0 and slot 5 valid, present pck 5 again -> o_ready=0 until pck 0..5 drain and exp passes 5. The second copy is then delivered as the next-window pck 5.
- Wrap: stream 20 in-order packets -> o_pck sequence 0..7,0..7,0..3; o_last pulses twice.
- Reset mid-stream: rst=0 for 1 cycle with slots 1,3 valid -> o_valid=0 the next cycle. Then send pck 0 -> delivered as o_pck 0; stale slots 1,3 are never emitted.
